// File: rtl/scan_code_receiver_if.sv
// Bundles the keyboard-side scan-code handshake and the consumer-side pop port.
// The receiver uses the slave view; the keyboard block/consumer use the master view.
interface scan_code_receiver_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       scan_code;
  logic             scan_code_ready;
  logic             input_done;
  logic             key_pop;
  logic [7:0]       key_code;
  logic             key_valid;
  logic [CNT_W-1:0] key_count;
  logic             overflow;

  modport slave (
    input  scan_code, scan_code_ready, key_pop,
    output input_done, key_code, key_valid, key_count, overflow
  );

  modport master (
    output scan_code, scan_code_ready, key_pop,
    input  input_done, key_code, key_valid, key_count, overflow
  );
endinterface

// File: rtl/scan_code_receiver.sv
// Scan-code receiver: edge-detects scan_code_ready and queues one key per high period.
// Optional macro SCAN_RX_DEDUP_EN drops events repeating the last accepted code.
module scan_code_receiver #(
  parameter int unsigned DEPTH = 4
) (
  input logic                  clk,
  input logic                  resetn,
  scan_code_receiver_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
`ifdef SCAN_RX_DEDUP_EN
  logic [7:0]       last_q, last_d;
`endif

  logic ev_c, full_c, empty_c, try_push_c, push_c, pop_c, drop_c;

  assign ev_c    = bus.scan_code_ready & ~rdy_q;
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == CNT_W'(0));
  assign pop_c   = bus.key_pop & ~empty_c;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: one capture per high period of scan_code_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ev_c && (bus.scan_code != 8'h00)) state_d = HOLD;
      HOLD: if (!bus.scan_code_ready)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: push attempt, accepted push, dropped push
  always_comb begin
    try_push_c = 1'b0;
    push_c     = 1'b0;
    drop_c     = 1'b0;
    if ((state_q == IDLE) && ev_c && (bus.scan_code != 8'h00)) begin
`ifdef SCAN_RX_DEDUP_EN
      try_push_c = (bus.scan_code != last_q);
`else
      try_push_c = 1'b1;
`endif
    end
    // A full FIFO still accepts when the head is popped in the same cycle
    push_c = try_push_c & (~full_c | bus.key_pop);
    drop_c = try_push_c & ~push_c;
  end

  // FIFO datapath next values
  always_comb begin
    rdy_d      = bus.scan_code_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop_c;
    mem_d      = mem_q;
`ifdef SCAN_RX_DEDUP_EN
    last_d     = last_q;
`endif
    if (push_c) begin
      mem_d[wr_ptr_q] = bus.scan_code;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
`ifdef SCAN_RX_DEDUP_EN
      last_d          = bus.scan_code;
`endif
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
`ifdef SCAN_RX_DEDUP_EN
      last_q     <= 8'h00;
`endif
    end else begin
      rdy_q      <= rdy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
`ifdef SCAN_RX_DEDUP_EN
      last_q     <= last_d;
`endif
    end
  end

  assign bus.input_done = ~full_c;
  assign bus.key_code   = mem_q[rd_ptr_q];
  assign bus.key_valid  = ~empty_c;
  assign bus.key_count  = count_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_scan_code_receiver.sv
// Directed bench for scan_code_receiver with a queue-based reference model checked every cycle.
module tb_scan_code_receiver;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  scan_code_receiver_if #(.DEPTH(DEPTH)) bus ();

  scan_code_receiver #(.DEPTH(DEPTH)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of accepted codes, updated from rising edges of ready
  logic [7:0] mq [$];
  bit         m_prev = 1'b0;
  bit         m_ovf  = 1'b0;
  logic [7:0] m_last = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        mq.delete();
        m_prev = 1'b0;
        m_ovf  = 1'b0;
        m_last = 8'h00;
      end else begin
        bit popped, rise, dup;
        logic [7:0] c;
        c      = bus.scan_code;
        popped = bus.key_pop && (mq.size() > 0);
        rise   = bus.scan_code_ready && !m_prev && (c != 8'h00);
`ifdef SCAN_RX_DEDUP_EN
        dup    = (c == m_last);
`else
        dup    = 1'b0;
`endif
        if (popped) void'(mq.pop_front());
        if (rise && !dup) begin
          if (mq.size() < int'(DEPTH)) begin
            mq.push_back(c);
            m_last = c;
          end else begin
            m_ovf = 1'b1;
          end
        end
        m_prev = bus.scan_code_ready;
      end
    end
  end

  // Compare DUT outputs against the model every cycle out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk("model_valid", int'(bus.key_valid), int'(mq.size() > 0));
        chk("model_count", int'(bus.key_count), mq.size());
        chk("model_input_done", int'(bus.input_done), int'(mq.size() < int'(DEPTH)));
        chk("model_overflow", int'(bus.overflow), int'(m_ovf));
        if (mq.size() > 0) chk("model_head", int'(bus.key_code), int'(mq[0]));
      end
    end
  end

  task automatic cyc(input logic r, input logic [7:0] c, input logic p);
    @(negedge clk);
    bus.scan_code_ready = r;
    bus.scan_code       = c;
    bus.key_pop         = p;
  endtask

  task automatic key(input logic [7:0] c, input int hold);
    repeat (hold) cyc(1'b1, c, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic pop_exp(input string name, input logic [7:0] exp);
    cyc(1'b0, 8'h00, 1'b1);
    chk(name, int'(bus.key_code), int'(exp));
  endtask

  initial begin
    bus.scan_code_ready = 1'b0;
    bus.scan_code       = 8'h00;
    bus.key_pop         = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(bus.key_valid), 0);
    chk("rst_count", int'(bus.key_count), 0);
    chk("rst_input_done", int'(bus.input_done), 1);
    chk("rst_code", int'(bus.key_code), 0);
    #2 resetn = 1'b1;

    // Single key held 5 cycles pushes once
    key(8'h1C, 5);
    chk("single_count", int'(bus.key_count), 1);
    chk("single_code", int'(bus.key_code), 8'h1C);
    pop_exp("single_pop", 8'h1C);
    cyc(1'b0, 8'h00, 1'b0);
    chk("single_empty", int'(bus.key_valid), 0);

    // Order and pointer wrap
    key(8'h11, 2); key(8'h22, 2); key(8'h33, 2); key(8'h44, 2);
    pop_exp("wrap_pop0", 8'h11);
    pop_exp("wrap_pop1", 8'h22);
    cyc(1'b0, 8'h00, 1'b0);
    key(8'h55, 2); key(8'h66, 2);
    chk("wrap_full_idone", int'(bus.input_done), 0);
    pop_exp("wrap_pop2", 8'h33);
    pop_exp("wrap_pop3", 8'h44);
    pop_exp("wrap_pop4", 8'h55);
    pop_exp("wrap_pop5", 8'h66);
    cyc(1'b0, 8'h00, 1'b0);
    chk("wrap_empty", int'(bus.key_valid), 0);

    // Full, overflow, then push accepted alongside a pop
    key(8'hA1, 1); key(8'hA2, 1); key(8'hA3, 1); key(8'hA4, 1);
    chk("full_idone", int'(bus.input_done), 0);
    key(8'h77, 2);
    chk("full_overflow", int'(bus.overflow), 1);
    chk("full_count", int'(bus.key_count), 4);
    cyc(1'b1, 8'h78, 1'b1);
    cyc(1'b1, 8'h78, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("full_pushpop_count", int'(bus.key_count), 4);
    pop_exp("full_pop0", 8'hA2);
    pop_exp("full_pop1", 8'hA3);
    pop_exp("full_pop2", 8'hA4);
    pop_exp("full_pop3", 8'h78);
    cyc(1'b0, 8'h00, 1'b0);

    // Zero code ignored; push+pop on empty keeps the push
    key(8'h00, 2);
    chk("zero_count", int'(bus.key_count), 0);
    cyc(1'b1, 8'h2A, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("emptypp_count", int'(bus.key_count), 1);
    chk("emptypp_code", int'(bus.key_code), 8'h2A);
    pop_exp("emptypp_pop", 8'h2A);
    cyc(1'b0, 8'h00, 1'b0);

    // Duplicate suppression
    key(8'h1C, 2); key(8'h1C, 2); key(8'h32, 2);
`ifdef SCAN_RX_DEDUP_EN
    chk("dedup_count", int'(bus.key_count), 2);
`else
    chk("dedup_count", int'(bus.key_count), 3);
`endif

    // Asynchronous reset mid-stream, ready held high across release
    @(negedge clk);
    #2;
    resetn = 1'b0;
    bus.scan_code_ready = 1'b1;
    bus.scan_code       = 8'h45;
    #1;
    chk("mid_rst_valid", int'(bus.key_valid), 0);
    chk("mid_rst_count", int'(bus.key_count), 0);
    chk("mid_rst_overflow", int'(bus.overflow), 0);
    chk("mid_rst_idone", int'(bus.input_done), 1);
    chk("mid_rst_code", int'(bus.key_code), 0);
    @(negedge clk);
    #2 resetn = 1'b1;
    cyc(1'b1, 8'h45, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("rel_count", int'(bus.key_count), 1);
    chk("rel_code", int'(bus.key_code), 8'h45);
    repeat (2) cyc(1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
